// File: rtl/simple_processor_feeder.sv
// Feeds a small stored program to a processor one instruction at a time,
// handshaking on Done and aborting with Error on a truncated mvi or a stall.
module simple_processor_feeder (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [4:0] ProgLen,
  input  logic       WrEn,
  input  logic [3:0] WrAddr,
  input  logic [8:0] WrData,
  input  logic       Done,
  output logic [8:0] DIN,
  output logic       Run,
  output logic       Busy,
  output logic       Finished,
  output logic       Error,
  output logic [4:0] InstrCount
);

  // state  | meaning
  // IDLE   | program memory writable, waiting for Start
  // ISSUE  | Run strobe, DIN = mem[pc], IR captured
  // IMM    | immediate word of mvi on DIN, waiting for Done
  // WAIT   | instruction word held on DIN, waiting for Done
  // FINISH | one-cycle Finished pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_FINISH
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  // Loaded on ISSUE; reaching zero without Done ends the run on the 15th cycle after Run.
  localparam logic [3:0] TMO_TOP = 4'd13;

  state_t      state, state_nx;
  logic [8:0]  mem [16];
  logic [4:0]  pc, pc_nx, pc_p1, len, len_nx, cnt_nx;
  logic [3:0]  tmo, tmo_nx;
  logic [8:0]  ir, ir_nx, din_nx;
  logic        err_nx;

  assign pc_p1 = pc + 5'd1;

  always_ff @(posedge Clock) begin
    if (WrEn && state == S_IDLE) mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      pc         <= '0;
      len        <= '0;
      tmo        <= '0;
      ir         <= '0;
      DIN        <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Finished   <= 1'b0;
      Error      <= 1'b0;
      InstrCount <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      len        <= len_nx;
      tmo        <= tmo_nx;
      ir         <= ir_nx;
      DIN        <= din_nx;
      Run        <= (state_nx == S_ISSUE);
      Busy       <= (state_nx != S_IDLE);
      Finished   <= (state_nx == S_FINISH);
      Error      <= err_nx;
      InstrCount <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    len_nx   = len;
    cnt_nx   = InstrCount;
    tmo_nx   = tmo;
    ir_nx    = ir;
    err_nx   = Error;
    din_nx   = '0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          len_nx   = (ProgLen > 5'd16) ? 5'd16 : ProgLen;
          pc_nx    = '0;
          cnt_nx   = '0;
          err_nx   = 1'b0;
          state_nx = (ProgLen == 5'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_nx = TMO_TOP;
        if (ir[8:6] == OP_MVI) begin
          if (pc_p1 < len) begin
            state_nx = S_IMM;
          end else begin
            err_nx   = 1'b1;
            state_nx = S_FINISH;
          end
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          pc_nx    = (state == S_IMM) ? pc + 5'd2 : pc_p1;
          cnt_nx   = InstrCount + 5'd1;
          state_nx = (pc_nx >= len) ? S_FINISH : S_ISSUE;
        end else if (tmo == 4'd0) begin
          err_nx   = 1'b1;
          state_nx = S_FINISH;
        end else begin
          tmo_nx = tmo - 4'd1;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    if (state_nx == S_ISSUE) ir_nx = mem[pc_nx[3:0]];

    case (state_nx)
      S_ISSUE: din_nx = mem[pc_nx[3:0]];
      S_IMM:   din_nx = mem[pc_p1[3:0]];
      S_WAIT:  din_nx = ir;
      default: din_nx = '0;
    endcase
  end

endmodule
